// File: rtl/alu_wide_sequencer.sv
// alu_wide_sequencer: splits one wide ALU request into 32-bit slices, LS word first, and reassembles the result
//   clk, rst_n                   clock, asynchronous active-low reset
//   req_valid/ready/opcode/a/b/cin  wide request handshake and operands
//   rsp_valid/ready/result/cout/err wide response handshake and result
//   alu_opcode/a/b/cin -> ALU, alu_result/cout <- ALU  one slice per RUN cycle
module alu_wide_sequencer #(
    parameter int WORDS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [2:0]          req_opcode,
    input  logic [32*WORDS-1:0] req_a,
    input  logic [32*WORDS-1:0] req_b,
    input  logic                req_cin,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [32*WORDS-1:0] rsp_result,
    output logic                rsp_cout,
    output logic                rsp_err,
    output logic [2:0]          alu_opcode,
    output logic [31:0]         alu_a,
    output logic [31:0]         alu_b,
    output logic                alu_cin,
    input  logic [31:0]         alu_result,
    input  logic                alu_cout
);
    localparam int W  = 32 * WORDS;
    localparam int IW = $clog2(WORDS);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, res_q, res_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            carry_q, carry_d, err_q, err_d;
    logic            accept, is_add, bad_op, last, run;

    assign accept = req_valid && req_ready;
    assign is_add = op_q == 3'b111;
    // 100/101/110 are the only encodings with bit 2 set that are not ADD
    assign bad_op = req_opcode[2] && !(&req_opcode);
    assign last   = idx_q == IW'(WORDS - 1);
    assign run    = state_q == RUN;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? (bad_op ? DONE : RUN) : IDLE;
            RUN:     state_d = last ? DONE : RUN;
            DONE:    state_d = rsp_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = state_q == IDLE;
        rsp_valid  = state_q == DONE;
        rsp_result = rsp_valid ? res_q : '0;
        rsp_cout   = rsp_valid && is_add && carry_q;
        rsp_err    = rsp_valid && err_q;
        alu_opcode = run ? op_q : 3'b000;
        alu_a      = run ? a_q[32*idx_q +: 32] : 32'h0;
        alu_b      = run ? b_q[32*idx_q +: 32] : 32'h0;
        alu_cin    = run && is_add && carry_q;
    end

    always_comb begin
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        err_d   = err_q;
        if (accept) begin
            op_d    = req_opcode;
            a_d     = req_a;
            b_d     = req_b;
            res_d   = '0;
            idx_d   = '0;
            carry_d = (req_opcode == 3'b111) && req_cin;
            err_d   = bad_op;
        end else if (run) begin
            res_d[32*idx_q +: 32] = alu_result;
            carry_d = is_add ? alu_cout : carry_q;
            idx_d   = last ? '0 : idx_q + 1'b1;
        end else if (rsp_valid && rsp_ready) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= 3'b000;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_alu_wide_sequencer.sv
// tb_alu_wide_sequencer: directed-vector bench for alu_wide_sequencer with a behavioural 32-bit ALU
module tb_alu_wide_sequencer;
    localparam int WORDS = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0, req_ready, req_cin = 1'b0;
    logic [2:0]   req_opcode = 3'b000;
    logic [127:0] req_a = '0, req_b = '0;
    logic         rsp_valid, rsp_ready = 1'b0, rsp_cout, rsp_err;
    logic [127:0] rsp_result;
    logic [2:0]   alu_opcode;
    logic [31:0]  alu_a, alu_b, alu_result;
    logic         alu_cin, alu_cout;

    int n_chk = 0, n_bad = 0;
    logic cin_seen, alu_seen;

    localparam logic [127:0] ONES = {128{1'b1}};

    alu_wide_sequencer #(.WORDS(WORDS)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_cout(rsp_cout), .rsp_err(rsp_err),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
        .alu_result(alu_result), .alu_cout(alu_cout)
    );

    always #5 clk = ~clk;

    always_comb begin
        alu_result = 32'h0;
        alu_cout   = 1'b0;
        case (alu_opcode)
            3'b000: alu_result = ~alu_a;
            3'b001: alu_result = alu_a & alu_b;
            3'b010: alu_result = alu_a | alu_b;
            3'b011: alu_result = alu_a ^ alu_b;
            3'b111: {alu_cout, alu_result} = {1'b0, alu_a} + {1'b0, alu_b} + {32'h0, alu_cin};
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // drives a request from a negedge, returns at the negedge after the accepting edge
    task automatic send(input logic [2:0] op, input logic [127:0] a, input logic [127:0] b, input logic cin);
        @(negedge clk);
        req_valid = 1'b1; req_opcode = op; req_a = a; req_b = b; req_cin = cin;
        check("req_ready_before_accept", {127'b0, req_ready}, 128'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // counts edges after the accepting edge until rsp_valid; records ALU drive seen meanwhile
    task automatic wait_rsp(input string tag, input int exp_lat);
        int lat = 0;
        cin_seen = 1'b0;
        alu_seen = 1'b0;
        while (!rsp_valid && lat < 50) begin
            cin_seen |= alu_cin;
            alu_seen |= |{alu_opcode, alu_a, alu_b, alu_cin};
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check(tag, 128'(lat), 128'(exp_lat));
    endtask

    task automatic chk_rsp(input string tag, input logic [127:0] res, input logic cout, input logic err);
        check({tag, "_result"}, rsp_result, res);
        check({tag, "_cout"}, {127'b0, rsp_cout}, {127'b0, cout});
        check({tag, "_err"}, {127'b0, rsp_err}, {127'b0, err});
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("ack_rsp_valid", {127'b0, rsp_valid}, 128'd0);
        check("ack_req_ready", {127'b0, req_ready}, 128'd1);
    endtask

    initial begin
        #12;
        check("rst_req_ready", {127'b0, req_ready}, 128'd1);
        check("rst_rsp_valid", {127'b0, rsp_valid}, 128'd0);
        check("rst_rsp_result", rsp_result, 128'd0);
        check("rst_alu", {91'b0, alu_opcode, alu_a, alu_b, alu_cin}, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        send(3'b111, 128'h00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'h1, 1'b0);
        wait_rsp("add_ripple_lat", WORDS);
        chk_rsp("add_ripple", 128'h00000001_00000000_00000000_00000000, 1'b0, 1'b0);
        ack();

        send(3'b111, ONES, 128'h0, 1'b1);
        wait_rsp("add_ovf_lat", WORDS);
        check("add_ovf_cin_seen", {127'b0, cin_seen}, 128'd1);
        chk_rsp("add_ovf", 128'h0, 1'b1, 1'b0);
        ack();

        send(3'b011, {16{8'hAA}}, ONES, 1'b1);
        wait_rsp("xor_lat", WORDS);
        check("xor_alu_cin", {127'b0, cin_seen}, 128'd0);
        chk_rsp("xor", {16{8'h55}}, 1'b0, 1'b0);
        ack();

        send(3'b000, 128'h00000000_FFFFFFFF_12345678_F0F0F0F0, ONES, 1'b0);
        wait_rsp("not_lat", WORDS);
        chk_rsp("not", 128'hFFFFFFFF_00000000_EDCBA987_0F0F0F0F, 1'b0, 1'b0);
        ack();

        send(3'b100, ONES, ONES, 1'b1);
        wait_rsp("err_lat", 0);
        check("err_alu_idle", {127'b0, alu_seen}, 128'd0);
        chk_rsp("err", 128'h0, 1'b0, 1'b1);
        ack();

        send(3'b010, 128'hF0000000_0000000F_00FF0000_12340000,
                     128'h0F000000_000000F0_FF000000_00005678, 1'b0);
        wait_rsp("bp_lat", WORDS);
        req_valid = 1'b1; req_opcode = 3'b001; req_a = ONES;
        req_b = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D; req_cin = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", {127'b0, rsp_valid}, 128'd1);
            check("bp_req_ready", {127'b0, req_ready}, 128'd0);
            chk_rsp("bp_hold", 128'hFF000000_000000FF_FFFF0000_12345678, 1'b0, 1'b0);
            @(posedge clk);
            @(negedge clk);
        end
        ack();
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("bp_next_accepted", {127'b0, req_ready}, 128'd0);
        wait_rsp("and_lat", WORDS);
        chk_rsp("and", 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, 1'b0, 1'b0);
        ack();

        send(3'b111, ONES, ONES, 1'b1);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_req_ready", {127'b0, req_ready}, 128'd1);
        check("abort_rsp_valid", {127'b0, rsp_valid}, 128'd0);
        check("abort_rsp_result", rsp_result, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send(3'b111, 128'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'h1, 1'b1);
        wait_rsp("post_rst_lat", WORDS);
        chk_rsp("post_rst_add", 128'h80000000_00000000_00000000_00000001, 1'b0, 1'b0);
        ack();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
